// File: rtl/bids_multi_core_pkg.sv
// Shared types for the multi-bidder bid-round engine: opcodes, error codes,
// per-bidder request/response records and the round FSM states.
package bids_multi_core_pkg;

  localparam int unsigned DEFAULT_NUM_BIDDERS = 3;
  localparam int unsigned DATAWIDTH           = 32;
  localparam int unsigned BIDAMTBITS          = DATAWIDTH / 2;

  typedef enum logic [3:0] {
    NO_OP        = 4'd0,
    UNLOCK       = 4'd1,
    LOCK         = 4'd2,
    LOADX        = 4'd3,
    LOADY        = 4'd4,
    LOADZ        = 4'd5,
    SETMASK      = 4'd6,
    SETTIMER     = 4'd7,
    SETBIDCHARGE = 4'd8
  } opcodes_t;

  // Generalised LOAD uses C_sel to pick the bidder; LOADY/LOADZ are retired.
  localparam opcodes_t LOAD = LOADX;

  typedef enum logic [2:0] {
    NOERROR            = 3'd0,
    BADKEY             = 3'd1,
    ALREADYUNLOCKED    = 3'd2,
    CSTARTWHENUNLOCKED = 3'd3,
    INVALID_OP         = 3'd4
  } outerrors_t;

  typedef enum logic [1:0] {
    NOBIDERROR        = 2'd0,
    ROUNDINACTIVE     = 2'd1,
    INSUFFICIENTFUNDS = 2'd2,
    INVALIDREQUEST    = 2'd3
  } biderrors_t;

  typedef struct packed {
    logic [BIDAMTBITS-1:0] bidAmt;
    logic                  bid;
    logic                  retract;
  } inputs_t;

  typedef struct packed {
    logic                 ack;
    biderrors_t           err;
    logic [DATAWIDTH-1:0] balance;
    logic                 win;
  } outputs_t;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    ROUND    = 2'd2,
    RESULT   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/bids_multi_core_if.sv
// Control port plus per-bidder request/response arrays of the bid-round engine.
interface bids_multi_core_if import bids_multi_core_pkg::*; #(
  parameter int unsigned NUM_BIDDERS = DEFAULT_NUM_BIDDERS
);

  localparam int unsigned SelW = $clog2(NUM_BIDDERS);

  opcodes_t             C_op;
  logic [DATAWIDTH-1:0] C_data;
  logic [SelW-1:0]      C_sel;
  logic                 C_start;
  inputs_t              bid_in  [NUM_BIDDERS];
  outputs_t             bid_out [NUM_BIDDERS];
  logic                 ready;
  outerrors_t           err;
  logic                 roundOver;
  logic [DATAWIDTH-1:0] maxBid;

  modport master (
    output C_op, C_data, C_sel, C_start, bid_in,
    input  bid_out, ready, err, roundOver, maxBid
  );

  modport slave (
    input  C_op, C_data, C_sel, C_start, bid_in,
    output bid_out, ready, err, roundOver, maxBid
  );

endinterface

// File: rtl/bids_bidder_slot.sv
// One bidder: balance and held-bid registers, request checking, bid charging
// and deduction of the winning bid.
module bids_bidder_slot import bids_multi_core_pkg::*; (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  round_active,
  input  logic                  mask_bit,
  input  logic [DATAWIDTH-1:0]  charge,
  input  logic                  load_en,
  input  logic [DATAWIDTH-1:0]  load_data,
  input  logic                  clear_held,
  input  logic                  win_en,
  input  inputs_t               req,
  output logic [BIDAMTBITS-1:0] held,
  output outputs_t              resp
);

  logic [DATAWIDTH-1:0]  balance_q, balance_d;
  logic [BIDAMTBITS-1:0] held_q, held_d;
  logic                  ack_q, ack_d;
  biderrors_t            err_q, err_d;
  logic                  win_q, win_d;
  logic [DATAWIDTH:0]    cost;

  always_comb begin
    balance_d = balance_q;
    held_d    = held_q;
    ack_d     = 1'b0;
    err_d     = NOBIDERROR;
    win_d     = 1'b0;
    // One extra bit so bidAmt + charge cannot wrap past the balance.
    cost = {1'b0, charge} + {{(DATAWIDTH + 1 - BIDAMTBITS){1'b0}}, req.bidAmt};

    if (load_en) balance_d = load_data;
    if (clear_held) held_d = '0;

    if (req.bid || req.retract) begin
      if (!round_active) begin
        err_d = ROUNDINACTIVE;
      end else if ((req.bid && req.retract) || !mask_bit) begin
        err_d = INVALIDREQUEST;
      end else if (req.bid && (cost > {1'b0, balance_q})) begin
        err_d = INSUFFICIENTFUNDS;
      end else begin
        ack_d = 1'b1;
        if (req.bid) begin
          balance_d = balance_q - charge;
          held_d    = req.bidAmt;
        end else begin
          held_d = '0;
        end
      end
    end

    if (win_en) begin
      win_d     = 1'b1;
      balance_d = balance_q - {{(DATAWIDTH - BIDAMTBITS){1'b0}}, held_q};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      balance_q <= '0;
      held_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= NOBIDERROR;
      win_q     <= 1'b0;
    end else begin
      balance_q <= balance_d;
      held_q    <= held_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      win_q     <= win_d;
    end
  end

  assign held = held_q;
  assign resp = '{ack: ack_q, err: err_q, balance: balance_q, win: win_q};

endmodule

// File: rtl/bids_multi_core.sv
// Bid-round engine: lock/config FSM, round timer and max/tie winner selection
// over an array of bidder slots.
module bids_multi_core import bids_multi_core_pkg::*; #(
  parameter int unsigned NUM_BIDDERS = DEFAULT_NUM_BIDDERS
) (
  input logic               clk,
  input logic               reset_n,
  bids_multi_core_if.slave  bus
);

  fsm_state_t             state_q, state_d;
  logic [DATAWIDTH-1:0]   key_q, key_d;
  logic [NUM_BIDDERS-1:0] mask_q, mask_d;
  logic [DATAWIDTH-1:0]   timer_q, timer_d;
  logic [DATAWIDTH-1:0]   charge_q, charge_d;
  logic [DATAWIDTH-1:0]   cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]   max_bid_q, max_bid_d;
  outerrors_t             err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   round_over_q, round_over_d;

  logic                   clear_held;
  logic                   round_active;
  logic [31:0]            sel_ext;
  logic                   sel_ok;
  logic [NUM_BIDDERS-1:0] load_en;
  logic [NUM_BIDDERS-1:0] win_sel;
  logic [NUM_BIDDERS-1:0] win_en;
  logic                   tie;
  logic [BIDAMTBITS-1:0]  max_held;
  logic [BIDAMTBITS-1:0]  held [NUM_BIDDERS];

  assign round_active = (state_q == ROUND);
  assign sel_ext      = 32'(bus.C_sel);
  assign sel_ok       = (sel_ext < NUM_BIDDERS);

  always_comb begin
    load_en = '0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      load_en[i] = (state_q == UNLOCKED) && (bus.C_op == LOAD) && sel_ok && (sel_ext == 32'(i));
    end
  end

  // Maximum held bid, then a one-hot of the holders; a second holder marks a tie.
  always_comb begin
    max_held = '0;
    win_sel  = '0;
    tie      = 1'b0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (held[i] > max_held) max_held = held[i];
    end
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (held[i] == max_held) begin
        if (|win_sel) tie = 1'b1;
        win_sel[i] = 1'b1;
      end
    end
    win_en = ((state_q == RESULT) && (max_held != '0) && !tie) ? win_sel : '0;
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    mask_d       = mask_q;
    timer_d      = timer_q;
    charge_d     = charge_q;
    cnt_d        = cnt_q;
    max_bid_d    = max_bid_q;
    err_d        = NOERROR;
    round_over_d = 1'b0;
    clear_held   = 1'b0;

    unique case (state_q)
      LOCKED: begin
        if (bus.C_op == UNLOCK) begin
          if (bus.C_data == key_q) state_d = UNLOCKED;
          else                     err_d   = BADKEY;
        end else if (bus.C_op != NO_OP) begin
          err_d = INVALID_OP;
        end
        if (bus.C_start) begin
          state_d    = ROUND;
          cnt_d      = timer_q;
          max_bid_d  = '0;
          clear_held = 1'b1;
        end
      end
      UNLOCKED: begin
        case (bus.C_op)
          NO_OP:        begin end
          LOAD:         if (!sel_ok) err_d = INVALID_OP;
          SETMASK:      mask_d   = bus.C_data[NUM_BIDDERS-1:0];
          SETTIMER:     timer_d  = bus.C_data;
          SETBIDCHARGE: charge_d = bus.C_data;
          LOCK: begin
            key_d   = bus.C_data;
            state_d = LOCKED;
          end
          UNLOCK:       err_d = ALREADYUNLOCKED;
          default:      err_d = INVALID_OP;
        endcase
        if (bus.C_start) err_d = CSTARTWHENUNLOCKED;
      end
      ROUND: begin
        if (bus.C_op != NO_OP) err_d = INVALID_OP;
        if (cnt_q == '0) state_d = RESULT;
        else             cnt_d   = cnt_q - DATAWIDTH'(1);
      end
      RESULT: begin
        max_bid_d    = {{(DATAWIDTH - BIDAMTBITS){1'b0}}, max_held};
        round_over_d = 1'b1;
        state_d      = LOCKED;
      end
      default: state_d = LOCKED;
    endcase

    ready_d = (state_d == LOCKED) || (state_d == UNLOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LOCKED;
      key_q        <= '0;
      mask_q       <= '1;
      timer_q      <= '0;
      charge_q     <= '0;
      cnt_q        <= '0;
      max_bid_q    <= '0;
      err_q        <= NOERROR;
      ready_q      <= 1'b1;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      charge_q     <= charge_d;
      cnt_q        <= cnt_d;
      max_bid_q    <= max_bid_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      round_over_q <= round_over_d;
    end
  end

  for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_slot
    bids_bidder_slot u_slot (
      .clk          (clk),
      .reset_n      (reset_n),
      .round_active (round_active),
      .mask_bit     (mask_q[g]),
      .charge       (charge_q),
      .load_en      (load_en[g]),
      .load_data    (bus.C_data),
      .clear_held   (clear_held),
      .win_en       (win_en[g]),
      .req          (bus.bid_in[g]),
      .held         (held[g]),
      .resp         (bus.bid_out[g])
    );
  end

  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.roundOver = round_over_q;
  assign bus.maxBid    = max_bid_q;

endmodule
